// File: rtl/zb_pkg.sv
// Shared constants for the 802.15.4 2.4 GHz DSSS spreader and despreader.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: chip/symbol widths, the 16-entry PN chip table (c0 in bit 0) and the spreader FSM states.
package zb_pkg;

  localparam int CHIPS_PER_SYMBOL = 32;
  localparam int SYMBOL_WIDTH     = 4;
  localparam int IDX_W            = $clog2(CHIPS_PER_SYMBOL);

  // Entry k (k = 1..7) is entry 0 rotated by 4*k chips toward higher chip indices.
  // Entries 8..15 are entries 0..7 with every odd-indexed chip inverted (XOR 0xAAAAAAAA).
  localparam logic [CHIPS_PER_SYMBOL-1:0] CHIP_TABLE [16] = '{
    32'h744AC39B, 32'h44AC39B7, 32'h4AC39B74, 32'hAC39B744,
    32'hC39B744A, 32'h39B744AC, 32'h9B744AC3, 32'hB744AC39,
    32'hDEE06931, 32'hEE06931D, 32'hE06931DE, 32'h06931DEE,
    32'h6931DEE0, 32'h931DEE06, 32'h31DEE069, 32'h1DEE0693
  };

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/zb_chip_spreader_if.sv
// Symbol-in / chip-out handshake bundle for the chip spreader.
// Latency: n/a (wiring only).
// Backpressure: symbol side valid/ready, chip side valid/ready per chip.
// slave = spreader side, master = symbol source + chip sink side.
interface zb_chip_spreader_if;
  import zb_pkg::*;

  logic [SYMBOL_WIDTH-1:0] inSymbol;
  logic                    inSymbolValid;
  logic                    outSymbolReady;
  logic                    outChip;
  logic                    outChipValid;
  logic                    inChipReady;
  logic                    outFirstChip;
  logic [IDX_W-1:0]        outChipIndex;
  logic                    outBusy;

  modport slave (
    input  inSymbol, inSymbolValid, inChipReady,
    output outSymbolReady, outChip, outChipValid, outFirstChip, outChipIndex, outBusy
  );

  modport master (
    output inSymbol, inSymbolValid, inChipReady,
    input  outSymbolReady, outChip, outChipValid, outFirstChip, outChipIndex, outBusy
  );

endinterface

// File: rtl/zb_chip_rom.sv
// Combinational symbol -> 32-chip PN word lookup (c0 in bit 0); shared with the despreader.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: sym (4-bit data symbol in), chips (32-bit chip word out).
module zb_chip_rom
  import zb_pkg::*;
(
  input  logic [SYMBOL_WIDTH-1:0]     sym,
  output logic [CHIPS_PER_SYMBOL-1:0] chips
);

  assign chips = CHIP_TABLE[sym];

endmodule

// File: rtl/zb_chip_spreader.sv
// DSSS spreader: one 4-bit symbol in, its 32-chip PN sequence out serially.
// Latency: symbol accepted at edge N presents c0 from cycle N+1; back-to-back symbols have no bubble.
// Backpressure: chip output stalls chip by chip on inChipReady; symbol input is only ready in IDLE or on the last-chip transfer.
// Ports: inClock, inReset (sync, active-high), bus (slave side of zb_chip_spreader_if).
module zb_chip_spreader
  import zb_pkg::*;
(
  input  logic               inClock,
  input  logic               inReset,
  zb_chip_spreader_if.slave  bus
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHIPS_PER_SYMBOL - 1);

  state_t                      state;
  state_t                      state_nxt;
  logic [CHIPS_PER_SYMBOL-1:0] shreg;
  logic [CHIPS_PER_SYMBOL-1:0] rom_word;
  logic [IDX_W-1:0]            idx;
  logic                        last;
  logic                        xfer;
  logic                        sym_rdy;
  logic                        accept;
  logic                        chip_vld;
  logic                        chip_dat;
  logic                        first;

  zb_chip_rom u_rom (
    .sym   (bus.inSymbol),
    .chips (rom_word)
  );

  always_ff @(posedge inClock) begin
    if (inReset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sym_rdy   = 1'b0;
    chip_vld  = 1'b0;
    chip_dat  = 1'b0;
    first     = 1'b0;
    xfer      = 1'b0;
    last      = (idx == LAST_IDX);

    case (state)
      IDLE: begin
        sym_rdy = 1'b1;
      end
      SEND: begin
        chip_vld = 1'b1;
        chip_dat = shreg[0];
        first    = (idx == '0);
        xfer     = bus.inChipReady;
        // Combinational from inChipReady so the next symbol loads on the
        // same edge that retires c31, keeping the chip stream gap-free.
        sym_rdy  = last && bus.inChipReady;
      end
    endcase

    // Reset beats acceptance: the source must not pop a symbol we drop.
    if (inReset) begin
      sym_rdy = 1'b0;
    end

    accept = bus.inSymbolValid && sym_rdy;

    case (state)
      IDLE: if (accept) state_nxt = SEND;
      SEND: if (xfer && last && !accept) state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge inClock) begin
    if (inReset) begin
      shreg <= '0;
      idx   <= '0;
    end else if (accept) begin
      shreg <= rom_word;
      idx   <= '0;
    end else if (xfer) begin
      shreg <= shreg >> 1;
      idx   <= last ? '0 : idx + IDX_W'(1);
    end
  end

  assign bus.outSymbolReady = sym_rdy;
  assign bus.outChipValid   = chip_vld;
  assign bus.outChip        = chip_dat;
  assign bus.outFirstChip   = first;
  assign bus.outChipIndex   = idx;
  assign bus.outBusy        = (state == SEND);

endmodule

// File: tb/tb_zb_chip_spreader.sv
// Scoreboard bench for zb_chip_spreader: expected chips are queued on each
// accepted symbol (built from the symbol-0 chip string, rotations and odd-chip
// inversion) and popped on each observed chip transfer.
module tb_zb_chip_spreader;
  import zb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  zb_chip_spreader_if bus ();

  zb_chip_spreader dut (
    .inClock (clk),
    .inReset (rst),
    .bus     (bus)
  );

  typedef struct packed {
    logic [4:0] idx;
    logic       chip;
  } exp_t;

  int         n_cmp = 0;
  int         n_err = 0;
  exp_t       exp_q[$];
  logic [3:0] sym_q[$];
  bit [0:31]  base_seq = 32'b1101_1001_1100_0011_0101_0010_0010_1110;
  int         gap_cnt = 0;
  int         chips_seen = 0;
  int         acc_in_send = 0;
  logic       prev_stall = 1'b0;
  logic       prev_chip;
  logic [4:0] prev_idx;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic ref_chip(input int sym, input int i);
    int   k;
    logic c;
    k = sym % 8;
    c = base_seq[(i - 4 * k + 32) % 32];
    if (sym >= 8 && (i % 2) == 1) c = ~c;
    return c;
  endfunction

  // Called at a negedge with inputs already driven; samples, scores, waits for next negedge.
  task automatic tick();
    exp_t e;
    #1;
    if (!rst) begin
      if (prev_stall && bus.outChipValid) begin
        check_val("stall_chip_stable", bus.outChip, prev_chip);
        check_val("stall_idx_stable", bus.outChipIndex, prev_idx);
      end
      if (bus.outChipValid && bus.inChipReady) begin
        check_val("chip_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check_val("chip", bus.outChip, e.chip);
          check_val("chip_idx", bus.outChipIndex, e.idx);
          check_val("first_chip", bus.outFirstChip, e.idx == 5'd0);
          chips_seen++;
        end
      end
      if (exp_q.size() > 0 && !bus.outChipValid) gap_cnt++;
      if (bus.inSymbolValid && bus.outSymbolReady) begin
        if (bus.outChipValid) begin
          acc_in_send++;
          check_val("accept_idx", bus.outChipIndex, 31);
        end
        for (int i = 0; i < 32; i++) begin
          e.idx  = 5'(i);
          e.chip = ref_chip(int'(bus.inSymbol), i);
          exp_q.push_back(e);
        end
        if (sym_q.size() > 0) void'(sym_q.pop_front());
      end
      prev_stall = bus.outChipValid && !bus.inChipReady;
      prev_chip  = bus.outChip;
      prev_idx   = bus.outChipIndex;
    end else begin
      prev_stall = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic drive_auto(input int rnd);
    bus.inSymbolValid = (sym_q.size() > 0);
    bus.inSymbol      = (sym_q.size() > 0) ? sym_q[0] : 4'd0;
    bus.inChipReady   = (rnd != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic run(input int rnd, input string tag);
    int cyc;
    cyc = 0;
    while ((sym_q.size() > 0 || exp_q.size() > 0 || bus.outBusy) && cyc < 5000) begin
      drive_auto(rnd);
      tick();
      cyc++;
    end
    check_val({tag, "_pending_left"}, exp_q.size() + sym_q.size(), 0);
    bus.inSymbolValid = 1'b0;
    bus.inChipReady   = 1'b1;
  endtask

  task automatic run_to_idx(input int target);
    int n;
    n = 0;
    while (!(bus.outChipValid && bus.outChipIndex == 5'(target)) && n < 200) begin
      drive_auto(0);
      tick();
      n++;
    end
    check_val("reach_idx", bus.outChipIndex, target);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst               = 1'b1;
    bus.inSymbol      = 4'd0;
    bus.inSymbolValid = 1'b0;
    bus.inChipReady   = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b0;
    #1;
    check_val("rst_chip_vld", bus.outChipValid, 0);
    check_val("rst_chip", bus.outChip, 0);
    check_val("rst_idx", bus.outChipIndex, 0);
    check_val("rst_first", bus.outFirstChip, 0);
    check_val("rst_busy", bus.outBusy, 0);
    check_val("rst_sym_rdy", bus.outSymbolReady, 1);
    @(negedge clk);

    // Single symbol, ready held high.
    base = chips_seen;
    sym_q.push_back(4'd0);
    run(0, "single");
    check_val("single_chips", chips_seen - base, 32);
    check_val("single_idle_vld", bus.outChipValid, 0);
    check_val("single_idle_busy", bus.outBusy, 0);

    // Back-to-back 1 then 8: no bubble, second accepted on the c31 edge.
    base = chips_seen;
    gap_cnt = 0;
    acc_in_send = 0;
    sym_q.push_back(4'd1);
    sym_q.push_back(4'd8);
    run(0, "b2b");
    check_val("b2b_chips", chips_seen - base, 64);
    check_val("b2b_gaps", gap_cnt, 0);
    check_val("b2b_accept_in_send", acc_in_send, 1);

    // Random backpressure on symbol 15.
    base = chips_seen;
    sym_q.push_back(4'd15);
    run(1, "bp");
    check_val("bp_chips", chips_seen - base, 32);

    // Last-chip stall: no acceptance until ready rises.
    base = chips_seen;
    sym_q.push_back(4'd2);
    sym_q.push_back(4'd4);
    run_to_idx(31);
    for (int i = 0; i < 3; i++) begin
      bus.inSymbolValid = 1'b1;
      bus.inSymbol      = sym_q[0];
      bus.inChipReady   = 1'b0;
      #1;
      check_val("stall_sym_rdy", bus.outSymbolReady, 0);
      check_val("stall_at_idx31", bus.outChipIndex, 31);
      tick();
    end
    bus.inChipReady = 1'b1;
    #1;
    check_val("release_sym_rdy", bus.outSymbolReady, 1);
    tick();
    check_val("release_consumed", sym_q.size(), 0);
    run(0, "stall");
    check_val("stall_chips", chips_seen - base, 64);

    // Reset at index 12 of symbol 5, with symbol 3 offered in the reset cycle.
    sym_q.push_back(4'd5);
    run_to_idx(12);
    rst               = 1'b1;
    sym_q.push_back(4'd3);
    bus.inSymbolValid = 1'b1;
    bus.inSymbol      = 4'd3;
    bus.inChipReady   = 1'b1;
    #1;
    check_val("rst_blocks_accept", bus.outSymbolReady, 0);
    tick();
    rst = 1'b0;
    exp_q.delete();
    prev_stall = 1'b0;
    check_val("midrst_chip_vld", bus.outChipValid, 0);
    check_val("midrst_busy", bus.outBusy, 0);
    check_val("midrst_idx", bus.outChipIndex, 0);
    check_val("midrst_sym_kept", sym_q.size(), 1);
    base = chips_seen;
    run(0, "after_rst");
    check_val("after_rst_chips", chips_seen - base, 32);

    // All 16 symbols with random ready.
    base = chips_seen;
    for (int s = 0; s < 16; s++) sym_q.push_back(4'(s));
    run(1, "all");
    check_val("all_chips", chips_seen - base, 512);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
